// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI controller and its command sequencer:
// sequencer state encoding and the control-register word layout.
package spi_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD_TX,
    ST_LAUNCH,
    ST_POLL_REQ,
    ST_POLL_CHK,
    ST_READ_REQ,
    ST_READ_CAP,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam int CTRL_SEND_BIT      = 0;
  localparam int CTRL_ALL_ONES_BIT  = 1;
  localparam int CTRL_ALL_ZEROS_BIT = 2;
  localparam int CTRL_TX_END_LSB    = 4;
  localparam int CTRL_TX_END_W      = 9;
  localparam int CTRL_RX_END_LSB    = 16;
  localparam int CTRL_RX_END_W      = 10;

  function automatic logic [31:0] pack_ctrl(
    input logic                     send,
    input logic                     all_ones,
    input logic                     all_zeros,
    input logic [CTRL_TX_END_W-1:0] n_tx_end,
    input logic [CTRL_RX_END_W-1:0] n_rx_end
  );
    logic [31:0] w;
    w = '0;
    w[CTRL_SEND_BIT]                          = send;
    w[CTRL_ALL_ONES_BIT]                      = all_ones;
    w[CTRL_ALL_ZEROS_BIT]                     = all_zeros;
    w[CTRL_TX_END_LSB +: CTRL_TX_END_W]       = n_tx_end;
    w[CTRL_RX_END_LSB +: CTRL_RX_END_W]       = n_rx_end;
    return w;
  endfunction

endpackage

// File: rtl/secuenciador_spi_detector_flanco.sv
// Rising-edge detector: one-cycle pulse when senal_i goes 0 -> 1.
// The history flop updates every cycle, so a held level fires only once.
module detector_flanco (
  input  logic clk_i,
  input  logic reset_i,
  input  logic senal_i,
  output logic flanco_o
);

  logic prev_q, prev_d;

  always_comb prev_d = senal_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) prev_q <= 1'b0;
    else         prev_q <= prev_d;
  end

  assign flanco_o = senal_i & ~prev_q;

endmodule

// File: rtl/secuenciador_spi.sv
// Command sequencer for the SPI controller: loads the TX buffer, launches the
// transfer, polls the send bit and reads back the RX bytes.
module secuenciador_spi
  import spi_ctrl_pkg::*;
#(
  parameter int         N_BYTES  = 4,
  parameter logic [7:0] TX_BASE  = 8'hA0,
  parameter int         POLL_MAX = 4096
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        inicio_i,
  input  logic [31:0] salida_i,
  output logic        wr_o,
  output logic        reg_sel_o,
  output logic [31:0] entrada_o,
  output logic [31:0] addr_o,
  output logic        ocupado_o,
  output logic        listo_o,
  output logic        error_o,
  output logic [7:0]  dato_o
);

  localparam int         PW   = $clog2(POLL_MAX + 1);
  localparam logic [2:0] LAST = 3'(N_BYTES - 1);

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [PW-1:0] poll_q, poll_d;
  logic          wr_q, wr_d, sel_q, sel_d;
  logic [31:0]   entrada_q, entrada_d;
  logic [2:0]    addr_q, addr_d;
  logic          ocupado_q, ocupado_d, listo_q, listo_d, error_q, error_d;
  logic [7:0]    dato_q, dato_d;
  logic          inicio_flanco;
  logic          salida_unused;

  assign salida_unused = ^salida_i[31:8];

  detector_flanco u_flanco (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .senal_i  (inicio_i),
    .flanco_o (inicio_flanco)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    poll_d  = poll_q;
    error_d = error_q;
    dato_d  = dato_q;
    case (state_q)
      ST_IDLE: if (inicio_flanco) begin
        idx_d   = '0;
        poll_d  = '0;
        error_d = 1'b0;
        state_d = ST_LOAD_TX;
      end
      ST_LOAD_TX: begin
        if (idx_q == LAST) state_d = ST_LAUNCH;
        else               idx_d   = idx_q + 3'd1;
      end
      ST_LAUNCH:   state_d = ST_POLL_REQ;
      ST_POLL_REQ: state_d = ST_POLL_CHK;
      ST_POLL_CHK: begin
        if (!salida_i[CTRL_SEND_BIT]) begin
          idx_d   = '0;
          state_d = ST_READ_REQ;
        end else begin
          poll_d = poll_q + 1'b1;
          if (poll_d == PW'(POLL_MAX)) begin
            error_d = 1'b1;
            state_d = ST_ERROR;
          end else begin
            state_d = ST_POLL_REQ;
          end
        end
      end
      ST_READ_REQ: state_d = ST_READ_CAP;
      ST_READ_CAP: begin
        if (idx_q == LAST) begin
          dato_d  = salida_i[7:0];
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = ST_READ_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered so they come out registered.
  always_comb begin
    wr_d      = 1'b0;
    sel_d     = 1'b0;
    addr_d    = '0;
    entrada_d = '0;
    listo_d   = 1'b0;
    ocupado_d = 1'b1;
    case (state_d)
      ST_LOAD_TX: begin
        wr_d      = 1'b1;
        sel_d     = 1'b1;
        addr_d    = idx_d;
        entrada_d = {24'b0, TX_BASE + {5'b0, idx_d}};
      end
      ST_LAUNCH: begin
        wr_d      = 1'b1;
        entrada_d = pack_ctrl(1'b1, 1'b0, 1'b0, 9'(N_BYTES - 1), 10'(N_BYTES - 1));
      end
      ST_READ_REQ, ST_READ_CAP: begin
        sel_d  = 1'b1;
        addr_d = idx_d;
      end
      ST_DONE: begin
        ocupado_d = 1'b0;
        listo_d   = 1'b1;
      end
      ST_IDLE, ST_ERROR: ocupado_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      poll_q    <= '0;
      wr_q      <= 1'b0;
      sel_q     <= 1'b0;
      entrada_q <= '0;
      addr_q    <= '0;
      ocupado_q <= 1'b0;
      listo_q   <= 1'b0;
      error_q   <= 1'b0;
      dato_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      poll_q    <= poll_d;
      wr_q      <= wr_d;
      sel_q     <= sel_d;
      entrada_q <= entrada_d;
      addr_q    <= addr_d;
      ocupado_q <= ocupado_d;
      listo_q   <= listo_d;
      error_q   <= error_d;
      dato_q    <= dato_d;
    end
  end

  assign wr_o      = wr_q;
  assign reg_sel_o = sel_q;
  assign entrada_o = entrada_q;
  assign addr_o    = {29'b0, addr_q};
  assign ocupado_o = ocupado_q;
  assign listo_o   = listo_q;
  assign error_o   = error_q;
  assign dato_o    = dato_q;

endmodule
